// File: rtl/ice51_uart_loader.sv
// ice51_uart_loader: UART boot loader sitting between the serial pin and the
// ice51 core. It receives 8N1 bytes and writes the first MEM_SIZE of them to
// code memory. It then releases the core through o_run and forwards every
// later byte to the core's UART RX path.
// Optional feature: define ICE51_LOADER_CKSUM_EN to require a trailing
// checksum byte (8-bit sum of the image) before the core is released.
module ice51_uart_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEM_SIZE     = 512,
   parameter int ADDR_W       = 9
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_uart_rx,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_run,
   output logic              o_rx_valid,
   output logic [7:0]        o_rx_data,
   output logic              o_frame_err,
   output logic              o_load_err
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0]     HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]     FULL_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      LD_LOAD,
      LD_CHECK,
      LD_RUN
   } ld_state_t;

   logic              rx_meta;
   logic              rx_sync;
   logic              rx_prev;
   rx_state_t         rx_state;
   rx_state_t         rx_next;
   logic [TW-1:0]     timer;
   logic              timer_done;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              good_byte;
   logic              bad_stop;
   ld_state_t         ld_state;
   ld_state_t         ld_next;
   logic [ADDR_W-1:0] count;
`ifdef ICE51_LOADER_CKSUM_EN
   logic [7:0]        sum;
`endif

   // Two-flop synchroniser plus one delayed copy for falling-edge detection;
   // reset to the idle-high line level so reset release cannot fake a start bit
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // The start bit is sampled after half a bit; every later bit one full bit on
   always_comb begin
      timer_done = (rx_state == RX_START) ? (timer == HALF_LAST) : (timer == FULL_LAST);
   end

   assign good_byte = (rx_state == RX_STOP) && timer_done && rx_sync;
   assign bad_stop  = (rx_state == RX_STOP) && timer_done && !rx_sync;

   // Receiver state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   // Receiver next state: a high start-bit sample is a glitch and is dropped
   // silently; a low stop bit waits for the line to return high
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:      if (rx_prev && !rx_sync) rx_next = RX_START;
         RX_START:     if (timer_done) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:      if (timer_done && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:      if (timer_done) rx_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_sync) rx_next = RX_IDLE;
         default:      rx_next = RX_IDLE;
      endcase
   end

   // Bit timer, bit index and LSB-first shift register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         timer   <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || timer_done)
            timer <= '0;
         else
            timer <= timer + 1'b1;
         if (rx_state == RX_START) begin
            bit_idx <= 3'd0;
         end else if (rx_state == RX_DATA && timer_done) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // Loader state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ld_state <= LD_LOAD;
      else       ld_state <= ld_next;
   end

   // Loader next state: leave LOAD only on the byte that fills the last address
   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_LOAD: begin
            if (good_byte && count == LAST_ADDR) begin
`ifdef ICE51_LOADER_CKSUM_EN
               ld_next = LD_CHECK;
`else
               ld_next = LD_RUN;
`endif
            end
         end
`ifdef ICE51_LOADER_CKSUM_EN
         LD_CHECK: if (good_byte) ld_next = (shreg == sum) ? LD_RUN : LD_LOAD;
`endif
         LD_RUN:  ld_next = LD_RUN;
         default: ld_next = LD_LOAD;
      endcase
   end

   // Registered outputs; o_run trails the RUN state by one cycle so it rises
   // the cycle after the final write (or the checksum byte)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= 8'h00;
         o_run       <= 1'b0;
         o_rx_valid  <= 1'b0;
         o_rx_data   <= 8'h00;
         o_frame_err <= 1'b0;
         count       <= '0;
`ifdef ICE51_LOADER_CKSUM_EN
         sum         <= 8'h00;
         o_load_err  <= 1'b0;
`endif
      end else begin
         o_mem_we    <= 1'b0;
         o_rx_valid  <= 1'b0;
         o_frame_err <= bad_stop;
         o_run       <= (ld_state == LD_RUN);
         if (good_byte) begin
            case (ld_state)
               LD_LOAD: begin
                  o_mem_we    <= 1'b1;
                  o_mem_addr  <= count;
                  o_mem_wdata <= shreg;
                  count       <= count + 1'b1;
`ifdef ICE51_LOADER_CKSUM_EN
                  sum         <= sum + shreg;
`endif
               end
`ifdef ICE51_LOADER_CKSUM_EN
               LD_CHECK: begin
                  if (shreg != sum) begin
                     o_load_err <= 1'b1;
                     count      <= '0;
                     sum        <= 8'h00;
                  end
               end
`endif
               LD_RUN: begin
                  o_rx_valid <= 1'b1;
                  o_rx_data  <= shreg;
               end
               default: ;
            endcase
         end
      end
   end

`ifndef ICE51_LOADER_CKSUM_EN
   assign o_load_err = 1'b0;
`endif

endmodule

// File: tb/tb_ice51_uart_loader.sv
// tb_ice51_uart_loader: directed bench for the UART boot loader. A short bit
// period keeps full 512-byte loads cheap; the glitch is scaled to stay
// shorter than half a bit. Define ICE51_LOADER_CKSUM_EN to exercise the
// checksum stage as well.
module tb_ice51_uart_loader;

   localparam int CPB = 5;
   localparam int MEM = 512;
   localparam int AW  = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          uart_rx;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          run;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          frame_err;
   logic          load_err;

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int we_count = 0;
   int rx_valid_count = 0;
   int frame_err_count = 0;
   int last_addr = 0;
   int last_data = 0;
   int last_rx_data = 0;
   int last_we_cycle = 0;
   int run_cycle = 0;
   bit run_seen = 1'b0;
   bit we_prev = 1'b0;
   bit rv_prev = 1'b0;
   bit fe_prev = 1'b0;

   ice51_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .MEM_SIZE    (MEM),
      .ADDR_W      (AW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_uart_rx  (uart_rx),
      .o_mem_we   (mem_we),
      .o_mem_addr (mem_addr),
      .o_mem_wdata(mem_wdata),
      .o_run      (run),
      .o_rx_valid (rx_valid),
      .o_rx_data  (rx_data),
      .o_frame_err(frame_err),
      .o_load_err (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Pulse monitor on the falling edge: counts strobes and enforces one-cycle width
   always @(negedge clk) begin
      if (we_prev) checkOutput("we_pulse_width", {31'd0, mem_we}, 0);
      if (rv_prev) checkOutput("rx_valid_pulse_width", {31'd0, rx_valid}, 0);
      if (fe_prev) checkOutput("frame_err_pulse_width", {31'd0, frame_err}, 0);
      if (mem_we) begin
         we_count++;
         last_addr = int'(mem_addr);
         last_data = int'(mem_wdata);
         if (mem_addr == 9'h1FF) last_we_cycle = cycle;
      end
      if (rx_valid) begin
         rx_valid_count++;
         last_rx_data = int'(rx_data);
      end
      if (frame_err) frame_err_count++;
      if (run && !run_seen) begin
         run_seen = 1'b1;
         run_cycle = cycle;
      end
      we_prev = mem_we;
      rv_prev = rx_valid;
      fe_prev = frame_err;
   end

   // Drives one 8N1 frame (called and returning on a falling edge)
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int gap);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         uart_rx = data[b];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic glitch();
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic loadImage(input bit inject, input bit use_const);
      int         base;
      int         rv_base;
      logic [7:0] data;
      base    = we_count;
      rv_base = rx_valid_count;
      for (int i = 0; i < MEM; i++) begin
         data = use_const ? 8'h01 : 8'(i ^ 32'h5A);
         if (inject && i == 5) begin
            int fe_base;
            int wb;
            fe_base = frame_err_count;
            wb      = we_count;
            applyStimulus(8'h33, 1'b0, 10);
            checkOutput("framing_err_count", frame_err_count, fe_base + 1);
            checkOutput("framing_no_write", we_count, wb);
            checkOutput("framing_addr_held", {23'd0, mem_addr}, 4);
            glitch();
            checkOutput("glitch_no_write", we_count, wb);
            checkOutput("glitch_no_frame_err", frame_err_count, fe_base + 1);
            checkOutput("glitch_no_rx_valid", rx_valid_count, rv_base);
            base = base - 0;
         end
         if (i == MEM - 1) checkOutput("run_low_before_last", {31'd0, run}, 0);
         applyStimulus(data, 1'b1, 2);
         checkOutput("we_count", we_count, base + i + 1);
         checkOutput("we_addr", last_addr, i);
         checkOutput("we_data", last_data, {24'd0, data});
      end
      checkOutput("no_rx_valid_in_load", rx_valid_count, rv_base);
   endtask

   initial begin
      int wb;
      int rb;
      rst     = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_we", {31'd0, mem_we}, 0);
      checkOutput("reset_addr", {23'd0, mem_addr}, 0);
      checkOutput("reset_wdata", {24'd0, mem_wdata}, 0);
      checkOutput("reset_run", {31'd0, run}, 0);
      checkOutput("reset_rx_valid", {31'd0, rx_valid}, 0);
      checkOutput("reset_rx_data", {24'd0, rx_data}, 0);
      checkOutput("reset_frame_err", {31'd0, frame_err}, 0);
      checkOutput("reset_load_err", {31'd0, load_err}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Full image load with a framing error and a glitch injected at byte 5
      loadImage(1'b1, 1'b0);
`ifdef ICE51_LOADER_CKSUM_EN
      wb = we_count;
      applyStimulus(8'h00, 1'b1, 2);
      checkOutput("cksum_not_written", we_count, wb);
      checkOutput("cksum_ok_no_err", {31'd0, load_err}, 0);
`else
      checkOutput("run_latency", run_cycle - last_we_cycle, 1);
`endif
      checkOutput("run_after_load", {31'd0, run}, 1);

      // Post-boot forwarding
      wb = we_count;
      rb = rx_valid_count;
      applyStimulus(8'hA5, 1'b1, 2);
      checkOutput("post_rx_valid_count", rx_valid_count, rb + 1);
      checkOutput("post_rx_data", last_rx_data, 32'hA5);
      checkOutput("post_no_write", we_count, wb);
      repeat (20) @(negedge clk);
      checkOutput("post_rx_data_held", {24'd0, rx_data}, 32'hA5);
      applyStimulus(8'h3C, 1'b1, 2);
      checkOutput("post2_rx_valid_count", rx_valid_count, rb + 2);
      checkOutput("post2_rx_data", last_rx_data, 32'h3C);
      glitch();
      checkOutput("post_glitch_rx_valid", rx_valid_count, rb + 2);
      checkOutput("post_no_write_end", we_count, wb);
      checkOutput("run_stays_high", {31'd0, run}, 1);

      // Reset, partial load of 100 bytes, then reset during byte 100's data bits
      rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_drops_run", {31'd0, run}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 100; i++) applyStimulus(8'(i ^ 32'h5A), 1'b1, 2);
      checkOutput("partial_last_addr", last_addr, 99);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int b = 0; b < 3; b++) begin
         uart_rx = b[0];
         repeat (CPB) @(negedge clk);
      end
      rst     = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midload_reset_addr", {23'd0, mem_addr}, 0);
      checkOutput("midload_reset_run", {31'd0, run}, 0);
      rst = 1'b0;
      run_seen = 1'b0;
      repeat (10) @(negedge clk);
      loadImage(1'b0, 1'b0);
`ifdef ICE51_LOADER_CKSUM_EN
      applyStimulus(8'h00, 1'b1, 2);
`endif
      checkOutput("run_after_reload", {31'd0, run}, 1);

`ifdef ICE51_LOADER_CKSUM_EN
      // Wrong checksum must block run and latch the error; a correct retry releases
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      loadImage(1'b0, 1'b1);
      applyStimulus(8'h01, 1'b1, 4);
      checkOutput("cksum_bad_err", {31'd0, load_err}, 1);
      checkOutput("cksum_bad_run", {31'd0, run}, 0);
      loadImage(1'b0, 1'b1);
      applyStimulus(8'h00, 1'b1, 4);
      checkOutput("cksum_good_run", {31'd0, run}, 1);
      checkOutput("cksum_err_sticky", {31'd0, load_err}, 1);
`else
      checkOutput("load_err_tied_low", {31'd0, load_err}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
